// File: rtl/db15_pkg.sv
// Shared definitions for the DB15 arcade-stick serial reader.
// Frame geometry, per-button bit positions within a player word, and
// the reader FSM state encoding.
package db15_pkg;

    localparam int unsigned FRAME_BITS      = 24;
    localparam int unsigned BITS_PER_PLAYER = 12;
    localparam int unsigned JOY_W           = 16;

    // Button positions inside one player's 12-bit field (LS FEDCBAUDLR)
    localparam int unsigned BIT_RIGHT = 0;
    localparam int unsigned BIT_LEFT  = 1;
    localparam int unsigned BIT_DOWN  = 2;
    localparam int unsigned BIT_UP    = 3;
    localparam int unsigned BIT_A     = 4;
    localparam int unsigned BIT_B     = 5;
    localparam int unsigned BIT_C     = 6;
    localparam int unsigned BIT_D     = 7;
    localparam int unsigned BIT_E     = 8;
    localparam int unsigned BIT_F     = 9;
    localparam int unsigned BIT_START = 10;
    localparam int unsigned BIT_SEL   = 11;

    typedef enum logic [2:0] {
        LOAD,
        LOAD_REL,
        SAMPLE,
        CLOCK,
        LATCH,
        GAP
    } state_t;

endpackage

// File: rtl/db15_serial_reader_if.sv
// Published joystick words from the DB15 reader.
//   joystick1/joystick2 : 16-bit active-high words, [15:12] always 0
//   frame_done          : one-clk strobe when a frame has been latched
// master = reader side (drives), slave = consumer side.
interface db15_serial_reader_if;
    import db15_pkg::*;

    logic [JOY_W-1:0] joystick1;
    logic [JOY_W-1:0] joystick2;
    logic             frame_done;

    modport master (output joystick1, joystick2, frame_done);
    modport slave  (input  joystick1, joystick2, frame_done);

endinterface

// File: rtl/sync2.sv
// Generic two-flop synchronizer with a configurable reset value.
//   clk, reset_n : clock and synchronous active-low reset
//   d            : asynchronous input
//   q            : input resynchronized to clk, two clocks late
module sync2 #(
    parameter int unsigned   W         = 1,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/db15_serial_reader.sv
// Serial front end for DB15 arcade-stick adapters: loads the 24-bit
// shift-register chain, clocks the bits in and publishes two debounced
// 16-bit joystick words.
//   clk, reset_n : system clock, synchronous active-low reset
//   JOY_DATA     : serial data from the chain (pressed = 0), asynchronous
//   JOY_CLK      : shift clock to the chain (chain shifts on rising edge)
//   JOY_LOAD     : parallel-load strobe, active low
//   joy          : joystick1/joystick2 words and frame_done strobe
module db15_serial_reader
    import db15_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 12,
    parameter int unsigned GAP_TICKS = 1000,
    parameter bit          DEBOUNCE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  JOY_DATA,
    output logic                  JOY_CLK,
    output logic                  JOY_LOAD,
    db15_serial_reader_if.master  joy
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = 5;
    localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

    logic                  data_sync;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;

    state_t                state, state_n;
    logic [BIT_W-1:0]      bit_idx, bit_n;
    logic [GAP_W-1:0]      gap_cnt, gap_n;
    logic [FRAME_BITS-1:0] raw, raw_n;
    logic [FRAME_BITS-1:0] prev_raw, prev_n;
    logic [FRAME_BITS-1:0] pub, pub_n;
    logic                  load_n, jclk_n, done_n;
    logic                  done_q;

    // JOY_DATA idles high (released / disconnected)
    sync2 #(.W(1), .RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (JOY_DATA),
        .q       (data_sync)
    );

    // Shift-tick divider
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n || tick) div_cnt <= '0;
        else                  div_cnt <= div_cnt + DIV_W'(1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= LOAD;
        else          state <= state_n;
    end

    // Each tick edge opens the tick named by `state` and closes the one
    // before it, so end-of-tick work (bit capture, publishing) is done on
    // the edge that opens the following state.
    always_comb begin
        state_n = state;
        bit_n   = bit_idx;
        gap_n   = gap_cnt;
        raw_n   = raw;
        prev_n  = prev_raw;
        pub_n   = pub;
        load_n  = JOY_LOAD;
        jclk_n  = JOY_CLK;
        done_n  = 1'b0;

        if (tick) begin
            unique case (state)
                LOAD: begin
                    load_n  = 1'b0;
                    jclk_n  = 1'b0;
                    state_n = LOAD_REL;
                end
                LOAD_REL: begin
                    load_n  = 1'b1;
                    bit_n   = '0;
                    state_n = SAMPLE;
                end
                SAMPLE: begin
                    jclk_n  = 1'b0;
                    state_n = CLOCK;
                end
                CLOCK: begin
                    // Closing SAMPLE: data has settled CLK_DIV-1 clocks
                    raw_n[bit_idx] = ~data_sync;
                    jclk_n         = 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        state_n = LATCH;
                    end else begin
                        bit_n   = BIT_W'(bit_idx + BIT_W'(1));
                        state_n = SAMPLE;
                    end
                end
                LATCH: begin
                    jclk_n  = 1'b0;
                    state_n = GAP;
                end
                GAP: begin
                    jclk_n = 1'b0;
                    load_n = 1'b1;
                    // First GAP edge closes LATCH: publish the frame
                    if (gap_cnt == '0) begin
                        if (!DEBOUNCE || (raw == prev_raw)) pub_n = raw;
                        prev_n = raw;
                        done_n = 1'b1;
                    end
                    if (gap_cnt == GAP_LAST) begin
                        gap_n   = '0;
                        state_n = LOAD;
                    end else begin
                        gap_n = GAP_W'(gap_cnt + GAP_W'(1));
                    end
                end
                default: state_n = LOAD;
            endcase
        end
    end

    // Datapath and registered pin/strobe outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_idx  <= '0;
            gap_cnt  <= '0;
            raw      <= '0;
            prev_raw <= '0;
            pub      <= '0;
            JOY_LOAD <= 1'b1;
            JOY_CLK  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            bit_idx  <= bit_n;
            gap_cnt  <= gap_n;
            raw      <= raw_n;
            prev_raw <= prev_n;
            pub      <= pub_n;
            JOY_LOAD <= load_n;
            JOY_CLK  <= jclk_n;
            done_q   <= done_n;
        end
    end

    assign joy.joystick1  = JOY_W'(pub[BITS_PER_PLAYER-1:0]);
    assign joy.joystick2  = JOY_W'(pub[FRAME_BITS-1:BITS_PER_PLAYER]);
    assign joy.frame_done = done_q;

endmodule

// File: tb/tb_db15_serial_reader.sv
// Bench for db15_serial_reader: two instances (debounce on / off) read a
// behavioural 24-bit chain whose data settles only one clk after each
// JOY_CLK fall. Frame expectations are queued by the stimulus and checked
// by a monitor on every frame_done, alongside pin-timing checks.
module tb_db15_serial_reader;
    import db15_pkg::*;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned GAP_TICKS  = 8;
    localparam int unsigned FRAME_CLKS = (51 + GAP_TICKS) * CLK_DIV;

    typedef struct packed {
        logic [15:0] d1_j1;
        logic [15:0] d1_j2;
        logic [15:0] d0_j1;
        logic [15:0] d0_j2;
    } exp_t;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        joy_data;
    logic [1:0]  jc, jl, fd;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exp_t        exp_q[$];
    logic [23:0] m_prev = '0;
    logic [23:0] m_deb  = '0;

    logic [23:0] btn      = '0;
    logic [23:0] sr       = '1;
    logic        jdata    = 1'b1;
    logic        pjc_m    = 1'b0;
    bit          settle   = 1'b0;
    bit          float_hi = 1'b0;

    db15_serial_reader_if jif0 ();
    db15_serial_reader_if jif1 ();

    db15_serial_reader #(.CLK_DIV(CLK_DIV), .GAP_TICKS(GAP_TICKS), .DEBOUNCE(1'b1)) dut_deb (
        .clk      (clk),
        .reset_n  (reset_n),
        .JOY_DATA (joy_data),
        .JOY_CLK  (jc[0]),
        .JOY_LOAD (jl[0]),
        .joy      (jif0)
    );

    db15_serial_reader #(.CLK_DIV(CLK_DIV), .GAP_TICKS(GAP_TICKS), .DEBOUNCE(1'b0)) dut_raw (
        .clk      (clk),
        .reset_n  (reset_n),
        .JOY_DATA (joy_data),
        .JOY_CLK  (jc[1]),
        .JOY_LOAD (jl[1]),
        .joy      (jif1)
    );

    assign fd       = {jif1.frame_done, jif0.frame_done};
    assign joy_data = float_hi ? 1'b1 : jdata;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame publishes when it equals the previous frame
    // (debounced instance) or always (raw instance).
    task automatic push_frame(input logic [23:0] b);
        exp_t e;
        if (b == m_prev) m_deb = b;
        m_prev   = b;
        e.d1_j1  = {4'h0, m_deb[11:0]};
        e.d1_j2  = {4'h0, m_deb[23:12]};
        e.d0_j1  = {4'h0, b[11:0]};
        e.d0_j2  = {4'h0, b[23:12]};
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        @(negedge clk);
        while (!fd[0]) @(negedge clk);
    endtask

    task automatic run_frame(input logic [23:0] b, input bit flt);
        btn      = b;
        float_hi = flt;
        push_frame(flt ? 24'h0 : b);
        wait_done();
    endtask

    // Chain model: 24 parallel-in/serial-out stages, serial-in tied high.
    // After each shift the output shows a wrong value until one clk after
    // JOY_CLK falls, then the true bit.
    always @(negedge clk) begin
        if (!jl[0]) begin
            sr     = ~btn;
            jdata  = sr[0];
            settle = 1'b0;
        end else begin
            if (jc[0] && !pjc_m) begin
                sr    = {1'b1, sr[23:1]};
                jdata = ~sr[0];
            end
            if (settle) begin
                jdata  = sr[0];
                settle = 1'b0;
            end
            if (!jc[0] && pjc_m) settle = 1'b1;
        end
        pjc_m = jc[0];
    end

    // Monitor: pin timing per instance plus scoreboard on frame_done
    int unsigned since_rst[2];
    int unsigned since_fd[2];
    int unsigned load_len[2];
    int unsigned rises[2];
    bit          load_seen[2];
    bit          fd_seen[2];
    logic [1:0]  pjc = '0;
    logic [1:0]  pjl = '1;

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                since_rst[i] = 0;
                since_fd[i]  = 0;
                load_len[i]  = 0;
                rises[i]     = 0;
                load_seen[i] = 1'b0;
                fd_seen[i]   = 1'b0;
            end
            pjc = '0;
            pjl = '1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                since_rst[i]++;
                since_fd[i]++;
                if (!jl[i] && pjl[i]) begin
                    load_len[i] = 0;
                    rises[i]    = 0;
                    if (!load_seen[i]) begin
                        check("first_load_delay", since_rst[i], CLK_DIV);
                        load_seen[i] = 1'b1;
                    end
                end
                if (!jl[i]) load_len[i]++;
                if (jc[i] && !pjc[i]) rises[i]++;
                if (fd[i]) begin
                    check("clk_rises_per_frame", rises[i], 24);
                    check("load_low_clks", load_len[i], CLK_DIV);
                    if (fd_seen[i]) check("frame_done_period", since_fd[i], FRAME_CLKS);
                    fd_seen[i]  = 1'b1;
                    since_fd[i] = 0;
                end
            end
            pjc = jc;
            pjl = jl;

            if (fd[0]) begin
                check("frame_done_both", 32'(fd[1]), 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame_done: got pulse expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("deb_joystick1", 32'(jif0.joystick1), 32'(e.d1_j1));
                    check("deb_joystick2", 32'(jif0.joystick2), 32'(e.d1_j2));
                    check("raw_joystick1", 32'(jif1.joystick1), 32'(e.d0_j1));
                    check("raw_joystick2", 32'(jif1.joystick2), 32'(e.d0_j2));
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_deb_j1"}, 32'(jif0.joystick1), 32'h0);
        check({tag, "_deb_j2"}, 32'(jif0.joystick2), 32'h0);
        check({tag, "_raw_j1"}, 32'(jif1.joystick1), 32'h0);
        check({tag, "_raw_j2"}, 32'(jif1.joystick2), 32'h0);
        check({tag, "_joy_load"}, 32'(jl), 32'h3);
        check({tag, "_joy_clk"}, 32'(jc), 32'h0);
        check({tag, "_frame_done"}, 32'(fd), 32'h0);
    endtask

    // Watchdog
    initial begin
        repeat (60000) @(posedge clk);
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: got no completion expected finish within 60000 clks");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Stimulus
    initial begin
        logic [23:0] b;
        int unsigned nr;

        repeat (4) @(negedge clk);
        check_reset_state("reset");
        @(negedge clk);
        #1 reset_n = 1'b1;

        // All released, then P1 start+up with P2 fire A held
        run_frame(24'h000000, 1'b0);
        b = 24'h0;
        b[BIT_START] = 1'b1;
        b[BIT_UP]    = 1'b1;
        b[BITS_PER_PLAYER + BIT_A] = 1'b1;
        run_frame(b, 1'b0);
        run_frame(b, 1'b0);

        // P1 right toggling every frame
        for (int i = 0; i < 6; i++) run_frame((i % 2 == 0) ? 24'h000001 : 24'h000000, 1'b0);

        // Random patterns, often repeated so the debounced words move too
        b = 24'h0;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 0) b = 24'($urandom());
            run_frame(b, 1'b0);
        end

        // Disconnected adapter: data floats high
        for (int i = 0; i < 3; i++) run_frame(24'hA5A5A5, 1'b1);

        // Everything pressed, then reset during bit 13 of the next frame
        run_frame(24'hFFFFFF, 1'b0);
        run_frame(24'hFFFFFF, 1'b0);
        check("pre_reset_deb_j1", 32'(jif0.joystick1), 32'(16'h0FFF));
        nr = 0;
        while (nr < 13) begin
            @(negedge clk);
            if (jc[0] && !pjc_m) nr++;
        end
        do @(negedge clk); while (jc[0]);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check_reset_state("midframe_reset");
        exp_q.delete();
        m_prev = '0;
        m_deb  = '0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        // Restart from LOAD; partial frame must never appear
        b = 24'($urandom());
        run_frame(b, 1'b0);
        run_frame(b, 1'b0);
        run_frame(24'h000800, 1'b0);
        run_frame(24'h000800, 1'b0);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
